// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multicycle MIPS multiply/divide unit controller with HI/LO result registers.
// Define MDU_DIV0_FAST_EN to complete divide-by-zero in one cycle (hi=src_a, lo=all ones).
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        stall_req,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        uns_q, uns_d, sa_q, sa_d, sb_q, sb_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
  logic        accept, div0;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shl, diff;
  logic [63:0] ma, mb, prod;
  assign accept = state_q == IDLE && start && !flush && !rst;
  assign abs_a  = src_a[31] ? -src_a : src_a;
  assign abs_b  = src_b[31] ? -src_b : src_b;
`ifdef MDU_DIV0_FAST_EN
  assign div0 = src_b == 32'd0;
`else
  assign div0 = 1'b0;
`endif
  // Low 64 bits of the extended product are correct for both signed and unsigned.
  assign ma   = uns_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign mb   = uns_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
  assign prod = ma * mb;
  assign shl  = {rem_q, quo_q[31]};
  assign diff = shl - {1'b0, b_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          uns_d = op[0];
          sa_d  = src_a[31];
          sb_d  = src_b[31];
          if (!op[1]) begin
            state_d = MUL;
            cnt_d   = 6'(MUL_LAT - 1);
            a_d     = src_a;
            b_d     = src_b;
          end else if (div0) begin
            state_d = DONE;
            hi_d    = src_a;
            lo_d    = '1;
          end else begin
            state_d = DIV;
            cnt_d   = 6'd32;
            rem_d   = '0;
            quo_d   = op[0] ? src_a : abs_a;
            b_d     = op[0] ? src_b : abs_b;
          end
        end
        MUL: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d      = DONE;
            {hi_d, lo_d} = prod;
          end
        end
        DIV: begin
          cnt_d   = cnt_q - 6'd1;
          rem_d   = diff[32] ? shl[31:0] : diff[31:0];
          quo_d   = {quo_q[30:0], ~diff[32]};
          state_d = cnt_q == 6'd1 ? FIX : DIV;
        end
        FIX: begin
          state_d = DONE;
          lo_d    = (!uns_q && (sa_q ^ sb_q)) ? -quo_q : quo_q;
          hi_d    = (!uns_q && sa_q) ? -rem_q : rem_q;
        end
        DONE: state_d = ex_stall ? DONE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy         = state_q != IDLE;
  assign result_valid = state_q == DONE;
  assign stall_req    = accept || state_q == MUL || state_q == DIV || state_q == FIX;
  assign hi           = hi_q;
  assign lo           = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: two DUTs (MUL_LAT 2 and 4) on shared stimulus, checked every cycle
// against an arithmetic reference model, plus directed literal cases.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic rst, start, flush, ex_stall;
  logic [1:0] op;
  logic [31:0] src_a, src_b;
  logic [1:0] stall, bsy, rv;
  logic [1:0][31:0] hi, lo;
  int checks = 0, errors = 0, cyc = 0;
`ifdef MDU_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  always #5 clk = ~clk;
  mdu_ctrl #(.MUL_LAT(2)) u0 (.clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .ex_stall(ex_stall), .stall_req(stall[0]), .busy(bsy[0]),
    .result_valid(rv[0]), .hi(hi[0]), .lo(lo[0]));
  mdu_ctrl #(.MUL_LAT(4)) u1 (.clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .ex_stall(ex_stall), .stall_req(stall[1]), .busy(bsy[1]),
    .result_valid(rv[1]), .hi(hi[1]), .lo(lo[1]));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) return 64'd0;
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction
  // Reference model: phase 0 idle, 1 computing, 2 result presented.
  int ph[2], left[2];
  logic [31:0] mh[2], ml[2], pend_h[2], pend_l[2];
  bit hv[2], pv[2];
  initial for (int k = 0; k < 2; k++) begin
    ph[k] = 0; left[k] = 0; mh[k] = 0; ml[k] = 0; hv[k] = 1; pv[k] = 1;
  end
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = 0; mh[k] = 0; ml[k] = 0; hv[k] = 1;
      end else if (flush) begin
        ph[k] = 0;
      end else if (ph[k] == 0) begin
        if (start) begin
          if (op[1] && src_b == 32'd0 && FAST) begin
            ph[k] = 2; mh[k] = src_a; ml[k] = '1; hv[k] = 1;
          end else begin
            ph[k] = 1;
            left[k] = (op[1] ? 34 : (k == 1 ? 4 : 2)) - 1;
            {pend_h[k], pend_l[k]} = calc(op, src_a, src_b);
            pv[k] = !(op[1] && src_b == 32'd0);
          end
        end
      end else if (ph[k] == 1) begin
        left[k]--;
        if (left[k] == 0) begin
          ph[k] = 2; mh[k] = pend_h[k]; ml[k] = pend_l[k]; hv[k] = pv[k];
        end
      end else if (!ex_stall) begin
        ph[k] = 0;
      end
    end
  end
  always @(negedge clk) if (cyc > 0) for (int k = 0; k < 2; k++) begin
    chk($sformatf("busy%0d c%0d", k, cyc), 64'(bsy[k]), 64'(ph[k] != 0));
    chk($sformatf("rv%0d c%0d", k, cyc), 64'(rv[k]), 64'(ph[k] == 2));
    chk($sformatf("stall%0d c%0d", k, cyc), 64'(stall[k]),
        64'(ph[k] == 1 || (ph[k] == 0 && start && !flush && !rst)));
    if (hv[k]) begin
      chk($sformatf("hi%0d c%0d", k, cyc), 64'(hi[k]), 64'(mh[k]));
      chk($sformatf("lo%0d c%0d", k, cyc), 64'(lo[k]), 64'(ml[k]));
    end
  end
  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int elat, input bit res, input logic [31:0] eh, input logic [31:0] el);
    int n;
    start = 1'b1; op = o; src_a = a; src_b = b;
    cyc1();
    start = 1'b0;
    n = 1;
    while (!rv[0] && n < 80) begin
      cyc1();
      n++;
    end
    chk($sformatf("lat op%0d", o), 64'(n), 64'(elat));
    if (res) begin
      chk($sformatf("hi op%0d", o), 64'(hi[0]), 64'(eh));
      chk($sformatf("lo op%0d", o), 64'(lo[0]), 64'(el));
    end
    repeat (3) cyc1();
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n, cnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; ex_stall = 1'b0; op = 2'd0; src_a = 0; src_b = 0;
    repeat (3) cyc1();
    chk("rst busy", 64'(bsy), 64'd0);
    chk("rst rv", 64'(rv), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst hilo", {hi[0], lo[0]}, 64'd0);
    rst = 1'b0;
    cyc1();
    run_op(2'd0, 32'hFFFFFFFE, 32'd3, 2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(2'd1, 32'hFFFFFFFE, 32'd3, 2, 1'b1, 32'h00000002, 32'hFFFFFFFA);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 34, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'd3, 32'd100, 32'd7, 34, 1'b1, 32'd2, 32'd14);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 34, 1'b1, 32'd0, 32'h80000000);
    run_op(2'd2, 32'd0, 32'd5, 34, 1'b1, 32'd0, 32'd0);
    run_op(2'd3, 32'd5, 32'd0, FAST ? 1 : 34, FAST, 32'd5, 32'hFFFFFFFF);
    // Result held under ex_stall; a start during DONE is ignored.
    start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    cyc1();
    start = 1'b0;
    n = 1;
    while (!rv[0] && n < 80) begin
      cyc1();
      n++;
    end
    chk("stall lat", 64'(n), 64'd2);
    ex_stall = 1'b1; start = 1'b1; op = 2'd1;
    cnt = 1;
    repeat (2) begin
      cyc1();
      cnt += int'(rv[0]);
    end
    cyc1();
    cnt += int'(rv[0]);
    ex_stall = 1'b0; start = 1'b0;
    cyc1();
    cnt += int'(rv[0]);
    chk("stall hold cnt", 64'(cnt), 64'd4);
    chk("stall hilo", {hi[0], lo[0]}, 64'hFFFFFFFF_FFFFFFEB);
    repeat (4) cyc1();
    // Flush at T+10 of a divide, then a fresh divide at T+11.
    start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd3;
    cyc1();
    start = 1'b0;
    repeat (9) cyc1();
    flush = 1'b1;
    cyc1();
    flush = 1'b0;
    chk("flush busy", 64'(bsy), 64'd0);
    run_op(2'd3, 32'd1000, 32'd3, 34, 1'b1, 32'd1, 32'd333);
    // Reset in the middle of a MUL_LAT=4 multiply.
    repeat (3) cyc1();
    start = 1'b1; op = 2'd0; src_a = 32'h12345678; src_b = 32'h9ABCDEF0;
    cyc1();
    start = 1'b0;
    cyc1();
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    chk("mrst busy1", 64'(bsy[1]), 64'd0);
    chk("mrst hilo1", {hi[1], lo[1]}, 64'd0);
    cnt = 0;
    repeat (6) begin
      cyc1();
      cnt += int'(rv[1]);
    end
    chk("mrst no rv1", 64'(cnt), 64'd0);
    repeat (3000) begin
      start = $urandom_range(0, 3) == 0;
      op = 2'($urandom);
      src_a = pick();
      src_b = pick();
      flush = $urandom_range(0, 63) == 0;
      ex_stall = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 299) == 0;
      cyc1();
    end
    start = 1'b0; ex_stall = 1'b0; rst = 1'b0; flush = 1'b1;
    cyc1();
    flush = 1'b0;
    cyc1();
    chk("final idle", 64'(bsy), 64'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
